// File: rtl/res_station_pool_if.sv
// Issue, CDB and dispatch signals of res_station_pool.
// master = issue stage / CDB / functional unit side, slave = the station.
interface res_station_pool_if #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int OP_W   = 3
);
  logic              Issue_valid;
  logic              Issue_ready;
  logic [OP_W-1:0]   Issue_op;
  logic [2:0]        Issue_rd;
  logic [DATA_W-1:0] Issue_Vj;
  logic [DATA_W-1:0] Issue_Vk;
  logic [TAG_W-1:0]  Issue_Qj;
  logic [TAG_W-1:0]  Issue_Qk;
  logic [TAG_W-1:0]  Issue_tag;
  logic              CDB_valid;
  logic [TAG_W-1:0]  CDB_tag;
  logic [DATA_W-1:0] CDB_value;
  logic              Disp_valid;
  logic              Disp_ready;
  logic [OP_W-1:0]   Disp_op;
  logic [DATA_W-1:0] Disp_Vj;
  logic [DATA_W-1:0] Disp_Vk;
  logic [TAG_W-1:0]  Disp_tag;
  logic [2:0]        Disp_rd;
  logic [DEPTH-1:0]  Busy_mask;

  modport master (
    output Issue_valid, Issue_op, Issue_rd, Issue_Vj, Issue_Vk, Issue_Qj, Issue_Qk,
    output CDB_valid, CDB_tag, CDB_value, Disp_ready,
    input  Issue_ready, Issue_tag, Disp_valid, Disp_op, Disp_Vj, Disp_Vk,
    input  Disp_tag, Disp_rd, Busy_mask
  );

  modport slave (
    input  Issue_valid, Issue_op, Issue_rd, Issue_Vj, Issue_Vk, Issue_Qj, Issue_Qk,
    input  CDB_valid, CDB_tag, CDB_value, Disp_ready,
    output Issue_ready, Issue_tag, Disp_valid, Disp_op, Disp_Vj, Disp_Vk,
    output Disp_tag, Disp_rd, Busy_mask
  );
endinterface

// File: rtl/res_station_pool.sv
// DEPTH-entry Tomasulo reservation station sharing one functional unit.
// Optional RS_AGE_ORDER_EN: dispatch the oldest READY entry instead of the lowest index.
module res_station_pool #(
  parameter int DEPTH    = 3,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 3,
  parameter int OP_W     = 3,
  parameter int TAG_BASE = 1
) (
  input logic               Clock,
  input logic               Reset,
  res_station_pool_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] SENTINEL = DATA_W'(16'hFFF0);

  typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} ent_state_e;

  ent_state_e        st_q [DEPTH];
  ent_state_e        st_d [DEPTH];
  logic [OP_W-1:0]   op_q [DEPTH];
  logic [OP_W-1:0]   op_d [DEPTH];
  logic [2:0]        rd_q [DEPTH];
  logic [2:0]        rd_d [DEPTH];
  logic [DATA_W-1:0] vj_q [DEPTH];
  logic [DATA_W-1:0] vj_d [DEPTH];
  logic [DATA_W-1:0] vk_q [DEPTH];
  logic [DATA_W-1:0] vk_d [DEPTH];
  logic [TAG_W-1:0]  qj_q [DEPTH];
  logic [TAG_W-1:0]  qj_d [DEPTH];
  logic [TAG_W-1:0]  qk_q [DEPTH];
  logic [TAG_W-1:0]  qk_d [DEPTH];

  logic              any_free;
  logic [IDX_W-1:0]  free_idx;
  logic              disp_found;
  logic [IDX_W-1:0]  disp_sel;
  logic [DEPTH-1:0]  busy;
  logic              issue_fire;
  logic              disp_fire;
  logic              fwd_j;
  logic              fwd_k;

`ifdef RS_AGE_ORDER_EN
  logic [IDX_W-1:0]  age_q [DEPTH];
  logic [IDX_W-1:0]  age_d [DEPTH];
  logic [IDX_W-1:0]  best_age;
  logic [IDX_W-1:0]  free_age;
  logic              free_hit;
  int unsigned       busy_cnt;
`endif

  function automatic logic [TAG_W-1:0] own_tag(input int unsigned i);
    return TAG_W'(TAG_BASE + i);
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        st_q[i] <= FREE;
        op_q[i] <= '0;
        rd_q[i] <= '0;
        vj_q[i] <= SENTINEL;
        vk_q[i] <= SENTINEL;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
`ifdef RS_AGE_ORDER_EN
        age_q[i] <= '0;
`endif
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        st_q[i] <= st_d[i];
        op_q[i] <= op_d[i];
        rd_q[i] <= rd_d[i];
        vj_q[i] <= vj_d[i];
        vk_q[i] <= vk_d[i];
        qj_q[i] <= qj_d[i];
        qk_q[i] <= qk_d[i];
`ifdef RS_AGE_ORDER_EN
        age_q[i] <= age_d[i];
`endif
      end
    end
  end

  always_comb begin
    issue_fire = bus.Issue_valid && bus.Issue_ready;
    disp_fire  = disp_found && bus.Disp_ready;
    fwd_j      = (bus.Issue_Qj != '0) && bus.CDB_valid && (bus.Issue_Qj == bus.CDB_tag);
    fwd_k      = (bus.Issue_Qk != '0) && bus.CDB_valid && (bus.Issue_Qk == bus.CDB_tag);
`ifdef RS_AGE_ORDER_EN
    // Ages are ranks among busy entries (0 = oldest); a free closes the gap above it.
    free_hit = 1'b0;
    free_age = '0;
    busy_cnt = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (st_q[i] != FREE) busy_cnt++;
      if (st_q[i] == EXEC && bus.CDB_valid && bus.CDB_tag == own_tag(i)) begin
        free_hit = 1'b1;
        free_age = age_q[i];
      end
    end
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      st_d[i] = st_q[i];
      op_d[i] = op_q[i];
      rd_d[i] = rd_q[i];
      vj_d[i] = vj_q[i];
      vk_d[i] = vk_q[i];
      qj_d[i] = qj_q[i];
      qk_d[i] = qk_q[i];
`ifdef RS_AGE_ORDER_EN
      age_d[i] = age_q[i];
      if (st_q[i] != FREE && free_hit && age_q[i] > free_age) age_d[i] = age_q[i] - 1'b1;
`endif
      case (st_q[i])
        FREE: begin
          if (issue_fire && free_idx == IDX_W'(i)) begin
            op_d[i] = bus.Issue_op;
            rd_d[i] = bus.Issue_rd;
            vj_d[i] = fwd_j ? bus.CDB_value : bus.Issue_Vj;
            vk_d[i] = fwd_k ? bus.CDB_value : bus.Issue_Vk;
            qj_d[i] = fwd_j ? '0 : bus.Issue_Qj;
            qk_d[i] = fwd_k ? '0 : bus.Issue_Qk;
            st_d[i] = (qj_d[i] == '0 && qk_d[i] == '0) ? READY : WAIT;
`ifdef RS_AGE_ORDER_EN
            age_d[i] = IDX_W'(busy_cnt - (free_hit ? 1 : 0));
`endif
          end
        end
        WAIT: begin
          if (bus.CDB_valid && qj_q[i] != '0 && qj_q[i] == bus.CDB_tag) begin
            vj_d[i] = bus.CDB_value;
            qj_d[i] = '0;
          end
          if (bus.CDB_valid && qk_q[i] != '0 && qk_q[i] == bus.CDB_tag) begin
            vk_d[i] = bus.CDB_value;
            qk_d[i] = '0;
          end
          if (qj_d[i] == '0 && qk_d[i] == '0) st_d[i] = READY;
        end
        READY: begin
          if (disp_fire && disp_sel == IDX_W'(i)) st_d[i] = EXEC;
        end
        default: begin
          if (bus.CDB_valid && bus.CDB_tag == own_tag(i)) begin
            st_d[i] = FREE;
            op_d[i] = '0;
            rd_d[i] = '0;
            vj_d[i] = SENTINEL;
            vk_d[i] = SENTINEL;
            qj_d[i] = '0;
            qk_d[i] = '0;
`ifdef RS_AGE_ORDER_EN
            age_d[i] = '0;
`endif
          end
        end
      endcase
    end
  end

  always_comb begin
    any_free   = 1'b0;
    free_idx   = '0;
    disp_found = 1'b0;
    disp_sel   = '0;
    busy       = '0;
`ifdef RS_AGE_ORDER_EN
    best_age   = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy[i] = (st_q[i] != FREE);
      if (st_q[i] == FREE && !any_free) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
`ifdef RS_AGE_ORDER_EN
      if (st_q[i] == READY && (!disp_found || age_q[i] < best_age)) begin
        disp_found = 1'b1;
        disp_sel   = IDX_W'(i);
        best_age   = age_q[i];
      end
`else
      if (st_q[i] == READY && !disp_found) begin
        disp_found = 1'b1;
        disp_sel   = IDX_W'(i);
      end
`endif
    end
    bus.Busy_mask   = busy;
    bus.Issue_ready = any_free && !Reset;
    bus.Issue_tag   = any_free ? own_tag(32'(free_idx)) : '0;
    bus.Disp_valid  = disp_found;
    if (disp_found) begin
      bus.Disp_op  = op_q[disp_sel];
      bus.Disp_rd  = rd_q[disp_sel];
      bus.Disp_Vj  = vj_q[disp_sel];
      bus.Disp_Vk  = vk_q[disp_sel];
      bus.Disp_tag = own_tag(32'(disp_sel));
    end else begin
      bus.Disp_op  = '0;
      bus.Disp_rd  = '0;
      bus.Disp_Vj  = SENTINEL;
      bus.Disp_Vk  = SENTINEL;
      bus.Disp_tag = '0;
    end
  end

endmodule

// File: tb/tb_res_station_pool.sv
// Bench for res_station_pool (DEPTH=3, TAG_BASE=1): directed table, corner sequences,
// then random traffic against an entry-list reference model.
module tb_res_station_pool;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  res_station_pool_if #(.DEPTH(3), .DATA_W(16), .TAG_W(3), .OP_W(3)) bus ();

  res_station_pool #(
    .DEPTH(3), .DATA_W(16), .TAG_W(3), .OP_W(3), .TAG_BASE(1)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        iv;
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [15:0] vj;
    logic [15:0] vk;
    logic [2:0]  qj;
    logic [2:0]  qk;
    logic        cv;
    logic [2:0]  ct;
    logic [15:0] cval;
    logic        dr;
    logic        e_ir;
    logic [2:0]  e_tag;
    logic [2:0]  e_busy;
    logic        e_dv;
    logic [2:0]  e_dtag;
    logic [15:0] e_vj;
    logic [15:0] e_vk;
  } vec_t;

  vec_t tbl [20];

  // Reference model: a list of entries, each either empty, pending, or handed to the FU.
  bit          m_busy [3];
  bit          m_sent [3];
  logic [2:0]  m_op   [3];
  logic [2:0]  m_rd   [3];
  logic [15:0] m_vj   [3];
  logic [15:0] m_vk   [3];
  logic [2:0]  m_qj   [3];
  logic [2:0]  m_qk   [3];
  int unsigned m_seq  [3];
  int unsigned seq_ctr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [2:0] op, input logic [2:0] rd,
                       input logic [15:0] vj, input logic [15:0] vk,
                       input logic [2:0] qj, input logic [2:0] qk,
                       input logic cv, input logic [2:0] ct, input logic [15:0] cval,
                       input logic dr);
    bus.Issue_valid = iv;
    bus.Issue_op    = op;
    bus.Issue_rd    = rd;
    bus.Issue_Vj    = vj;
    bus.Issue_Vk    = vk;
    bus.Issue_Qj    = qj;
    bus.Issue_Qk    = qk;
    bus.CDB_valid   = cv;
    bus.CDB_tag     = ct;
    bus.CDB_value   = cval;
    bus.Disp_ready  = dr;
  endtask

  task automatic idle(input logic dr);
    drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, dr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(1'b0);
    #1;
    chk("rst_issue_ready_low", 32'(bus.Issue_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_issue_ready", 32'(bus.Issue_ready), 32'd1);
    chk("rst_issue_tag", 32'(bus.Issue_tag), 32'd1);
    chk("rst_busy", 32'(bus.Busy_mask), 32'd0);
    chk("rst_disp_valid", 32'(bus.Disp_valid), 32'd0);
    chk("rst_disp_vj", 32'(bus.Disp_Vj), 32'hFFF0);
    chk("rst_disp_vk", 32'(bus.Disp_Vk), 32'hFFF0);
    chk("rst_disp_op", 32'(bus.Disp_op), 32'd0);
    chk("rst_disp_tag", 32'(bus.Disp_tag), 32'd0);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0;
      m_sent[i] = 1'b0;
      m_qj[i]   = '0;
      m_qk[i]   = '0;
    end
  endfunction

  initial begin
    logic [2:0]  age_tag;
    logic [15:0] age_vj;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle(1'b0);

    // iv op rd vj vk qj qk | cv ct cval | dr || ir tag busy dv dtag dvj dvk
    tbl[0]  = '{1'b1,3'd1,3'd2,16'h5,16'h7,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b0, 1'b1,3'd1,3'b000,1'b0,3'd0,16'h0,16'h0};
    tbl[1]  = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b0, 1'b1,3'd2,3'b001,1'b1,3'd1,16'h5,16'h7};
    tbl[2]  = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b1, 1'b1,3'd2,3'b001,1'b1,3'd1,16'h5,16'h7};
    tbl[3]  = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b0, 1'b1,3'd2,3'b001,1'b0,3'd0,16'h0,16'h0};
    tbl[4]  = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b1,3'd1,16'h1234,1'b0, 1'b1,3'd2,3'b001,1'b0,3'd0,16'h0,16'h0};
    tbl[5]  = '{1'b1,3'd2,3'd3,16'h0,16'h4,3'd3,3'd0, 1'b0,3'd0,16'h0, 1'b0, 1'b1,3'd1,3'b000,1'b0,3'd0,16'h0,16'h0};
    tbl[6]  = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b0, 1'b1,3'd2,3'b001,1'b0,3'd0,16'h0,16'h0};
    tbl[7]  = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b1,3'd3,16'h00AB,1'b0, 1'b1,3'd2,3'b001,1'b0,3'd0,16'h0,16'h0};
    tbl[8]  = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b0, 1'b1,3'd2,3'b001,1'b1,3'd1,16'h00AB,16'h4};
    tbl[9]  = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b1, 1'b1,3'd2,3'b001,1'b1,3'd1,16'h00AB,16'h4};
    tbl[10] = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b1,3'd1,16'h0, 1'b0, 1'b1,3'd2,3'b001,1'b0,3'd0,16'h0,16'h0};
    tbl[11] = '{1'b1,3'd3,3'd1,16'h55,16'h66,3'd2,3'd2, 1'b1,3'd2,16'h9, 1'b0, 1'b1,3'd1,3'b000,1'b0,3'd0,16'h0,16'h0};
    tbl[12] = '{1'b1,3'd3,3'd4,16'h1,16'h2,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b0, 1'b1,3'd2,3'b001,1'b1,3'd1,16'h9,16'h9};
    tbl[13] = '{1'b1,3'd4,3'd5,16'h3,16'h4,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b0, 1'b1,3'd3,3'b011,1'b1,3'd1,16'h9,16'h9};
    tbl[14] = '{1'b1,3'd7,3'd7,16'hEE,16'hEE,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b0, 1'b0,3'd0,3'b111,1'b1,3'd1,16'h9,16'h9};
    tbl[15] = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b1, 1'b0,3'd0,3'b111,1'b1,3'd1,16'h9,16'h9};
    tbl[16] = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b1, 1'b0,3'd0,3'b111,1'b1,3'd2,16'h1,16'h2};
    tbl[17] = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b1,3'd2,16'h0, 1'b0, 1'b0,3'd0,3'b111,1'b1,3'd3,16'h3,16'h4};
    tbl[18] = '{1'b1,3'd5,3'd6,16'h6,16'h7,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b0, 1'b1,3'd2,3'b101,1'b1,3'd3,16'h3,16'h4};
`ifdef RS_AGE_ORDER_EN
    tbl[19] = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b0, 1'b0,3'd0,3'b111,1'b1,3'd3,16'h3,16'h4};
`else
    tbl[19] = '{1'b0,3'd0,3'd0,16'h0,16'h0,3'd0,3'd0, 1'b0,3'd0,16'h0, 1'b0, 1'b0,3'd0,3'b111,1'b1,3'd2,16'h6,16'h7};
`endif

    do_reset();
    for (int r = 0; r < 20; r++) begin
      @(negedge clk);
      drive(tbl[r].iv, tbl[r].op, tbl[r].rd, tbl[r].vj, tbl[r].vk, tbl[r].qj, tbl[r].qk,
            tbl[r].cv, tbl[r].ct, tbl[r].cval, tbl[r].dr);
      #1;
      chk($sformatf("tbl%0d_issue_ready", r), 32'(bus.Issue_ready), 32'(tbl[r].e_ir));
      chk($sformatf("tbl%0d_issue_tag", r), 32'(bus.Issue_tag), 32'(tbl[r].e_tag));
      chk($sformatf("tbl%0d_busy", r), 32'(bus.Busy_mask), 32'(tbl[r].e_busy));
      chk($sformatf("tbl%0d_disp_valid", r), 32'(bus.Disp_valid), 32'(tbl[r].e_dv));
      if (tbl[r].e_dv) begin
        chk($sformatf("tbl%0d_disp_tag", r), 32'(bus.Disp_tag), 32'(tbl[r].e_dtag));
        chk($sformatf("tbl%0d_disp_vj", r), 32'(bus.Disp_Vj), 32'(tbl[r].e_vj));
        chk($sformatf("tbl%0d_disp_vk", r), 32'(bus.Disp_Vk), 32'(tbl[r].e_vk));
      end
    end

    // Entry 2 issued first and still READY, entry 0 reissued later.
`ifdef RS_AGE_ORDER_EN
    age_tag = 3'd3;
    age_vj  = 16'd12;
`else
    age_tag = 3'd1;
    age_vj  = 16'd13;
`endif
    do_reset();
    @(negedge clk); drive(1'b1, 3'd1, 3'd1, 16'd10, 16'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
    @(negedge clk); drive(1'b1, 3'd2, 3'd2, 16'd11, 16'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
    @(negedge clk); drive(1'b1, 3'd3, 3'd3, 16'd12, 16'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1);
    #1 chk("age_c2_disp_tag", 32'(bus.Disp_tag), 32'd1);
    @(negedge clk); idle(1'b1);
    #1 chk("age_c3_disp_tag", 32'(bus.Disp_tag), 32'd2);
    @(negedge clk); drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b1, 3'd1, 16'h0, 1'b0);
    #1 chk("age_c4_disp_tag", 32'(bus.Disp_tag), 32'd3);
    @(negedge clk); drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b1, 3'd2, 16'h0, 1'b0);
    #1 chk("age_c5_busy", 32'(bus.Busy_mask), 32'b110);
    @(negedge clk); drive(1'b1, 3'd6, 3'd6, 16'd13, 16'd14, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
    #1 chk("age_c6_issue_tag", 32'(bus.Issue_tag), 32'd1);
    @(negedge clk); idle(1'b0);
    #1;
    chk("age_busy", 32'(bus.Busy_mask), 32'b101);
    chk("age_disp_tag", 32'(bus.Disp_tag), 32'(age_tag));
    chk("age_disp_vj", 32'(bus.Disp_Vj), 32'(age_vj));
    @(negedge clk); idle(1'b1);
    // The selected entry is now in EXEC; reset must discard it.
    @(negedge clk); idle(1'b0); rst = 1'b1;
    #1 chk("exec_rst_issue_ready", 32'(bus.Issue_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b1, age_tag, 16'h77, 1'b1);
    #1;
    chk("exec_rst_busy", 32'(bus.Busy_mask), 32'd0);
    chk("exec_rst_disp_valid", 32'(bus.Disp_valid), 32'd0);
    @(negedge clk); idle(1'b1);
    #1;
    chk("exec_rst_late_cdb_busy", 32'(bus.Busy_mask), 32'd0);
    chk("exec_rst_late_cdb_dv", 32'(bus.Disp_valid), 32'd0);
    chk("exec_rst_late_cdb_tag", 32'(bus.Issue_tag), 32'd1);

    // Random traffic against the reference model.
    do_reset();
    m_reset();
    seq_ctr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r_rst, iv, cv, dr;
      logic [2:0]  op, rd, qj, qk, ct;
      logic [15:0] vj, vk, cval;
      logic [2:0]  exp_busy;
      int          fi, rs;
      @(negedge clk);
      r_rst = ($urandom_range(0, 199) == 0);
      iv    = ($urandom_range(0, 2) != 0);
      op    = 3'($urandom);
      rd    = 3'($urandom);
      vj    = 16'($urandom);
      vk    = 16'($urandom);
      qj    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 3));
      qk    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 3));
      cv    = ($urandom_range(0, 1) == 0);
      ct    = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(1, 3));
      cval  = 16'($urandom);
      dr    = ($urandom_range(0, 2) != 0);
      rst   = r_rst;
      drive(iv, op, rd, vj, vk, qj, qk, cv, ct, cval, dr);
      #1;
      fi = -1;
      rs = -1;
      exp_busy = '0;
      for (int i = 0; i < 3; i++) begin
        exp_busy[i] = m_busy[i];
        if (!m_busy[i] && fi < 0) fi = i;
        if (m_busy[i] && !m_sent[i] && m_qj[i] == 3'd0 && m_qk[i] == 3'd0) begin
`ifdef RS_AGE_ORDER_EN
          if (rs < 0 || m_seq[i] < m_seq[rs]) rs = i;
`else
          if (rs < 0) rs = i;
`endif
        end
      end
      chk("rnd_issue_ready", 32'(bus.Issue_ready), 32'((fi >= 0) && !r_rst));
      chk("rnd_issue_tag", 32'(bus.Issue_tag), (fi >= 0) ? 32'(fi + 1) : 32'd0);
      chk("rnd_busy", 32'(bus.Busy_mask), 32'(exp_busy));
      chk("rnd_disp_valid", 32'(bus.Disp_valid), 32'(rs >= 0));
      if (rs >= 0) begin
        chk("rnd_disp_tag", 32'(bus.Disp_tag), 32'(rs + 1));
        chk("rnd_disp_op", 32'(bus.Disp_op), 32'(m_op[rs]));
        chk("rnd_disp_rd", 32'(bus.Disp_rd), 32'(m_rd[rs]));
        chk("rnd_disp_vj", 32'(bus.Disp_Vj), 32'(m_vj[rs]));
        chk("rnd_disp_vk", 32'(bus.Disp_Vk), 32'(m_vk[rs]));
      end
      if (r_rst) begin
        m_reset();
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (m_busy[i] && m_sent[i] && cv && ct == 3'(i + 1)) begin
            m_busy[i] = 1'b0;
            m_sent[i] = 1'b0;
          end else if (m_busy[i] && !m_sent[i] && cv) begin
            if (m_qj[i] != 3'd0 && m_qj[i] == ct) begin m_vj[i] = cval; m_qj[i] = 3'd0; end
            if (m_qk[i] != 3'd0 && m_qk[i] == ct) begin m_vk[i] = cval; m_qk[i] = 3'd0; end
          end
        end
        if (rs >= 0 && dr) m_sent[rs] = 1'b1;
        if (iv && fi >= 0) begin
          m_busy[fi] = 1'b1;
          m_sent[fi] = 1'b0;
          m_op[fi]   = op;
          m_rd[fi]   = rd;
          m_seq[fi]  = seq_ctr++;
          if (cv && qj != 3'd0 && qj == ct) begin m_vj[fi] = cval; m_qj[fi] = 3'd0; end
          else begin m_vj[fi] = vj; m_qj[fi] = qj; end
          if (cv && qk != 3'd0 && qk == ct) begin m_vk[fi] = cval; m_qk[fi] = 3'd0; end
          else begin m_vk[fi] = vk; m_qk[fi] = qk; end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
